sfx_sequencer: RTL and testbench

Game-side driver for the audio unit. Converts raw gameplay events and state levels into the audio unit's control inputs:
- one-cycle `play_*` / `stop_ufo` pulses;
- a time-varying `fleet_period` that plays the four-note fleet march at a tempo set by the number of surviving aliens.

It sits between the game logic and the audio unit. It owns all sound policy (tempo, rate limiting, muting), so the audio unit only renders.

---
 rtl/sfx_sequencer_pkg.sv | 20 ++
 rtl/sfx_sequencer_event_pulser.sv | 47 ++++
 rtl/sfx_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_sfx_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_sequencer_pkg.sv
// Shared definitions for the sound-effect sequencer: fleet FSM encoding and
// the march note table.
package sfx_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TONE  = 2'd1,
        ST_GAP   = 2'd2,
        ST_MUTED = 2'd3
    } fleet_state_t;

    // Four descending march notes, in Hz.
    localparam int unsigned NOTE_HZ [4] = '{98, 87, 78, 73};

    function automatic logic [31:0] note_period(input int unsigned clk_freq,
                                                input logic [1:0]  idx);
        return 32'(clk_freq / NOTE_HZ[idx]);
    endfunction

endpackage

// File: rtl/sfx_sequencer_event_pulser.sv
// One event channel: gated trigger in, optional holdoff window, registered
// single-cycle pulse out.
module sfx_sequencer_event_pulser #(
    parameter int unsigned HOLDOFF = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    input  logic enable,
    output logic pulse
);

    logic ready;
    logic accept;

    assign accept = trig & enable & ready;

    generate
        if (HOLDOFF > 0) begin : g_hold
            logic [31:0] hold_cnt;

            // Only accepted triggers restart the window; rejected ones leave it running.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_cnt <= '0;
                end else if (accept) begin
                    hold_cnt <= 32'(HOLDOFF - 1);
                end else if (hold_cnt != 32'd0) begin
                    hold_cnt <= hold_cnt - 32'd1;
                end
            end

            assign ready = (hold_cnt == 32'd0);
        end else begin : g_no_hold
            assign ready = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= 1'b0;
        end else begin
            pulse <= accept;
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Game-side sound policy: converts gameplay events into one-cycle audio-unit
// pulses and drives the alien-count-paced fleet march period.
module sfx_sequencer
    import sfx_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 100_000_000,
    parameter int unsigned NOTE_CYCLES     = CLK_FREQ / 10,
    parameter int unsigned MIN_STEP_CYCLES = CLK_FREQ / 20,
    parameter int unsigned STEP_PER_ALIEN  = CLK_FREQ / 100,
    parameter int unsigned SHOOT_HOLDOFF   = CLK_FREQ / 20,
    parameter int unsigned MUTE_CYCLES     = CLK_FREQ
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_active,
    input  logic [5:0]  alien_count,
    input  logic        ufo_active,
    input  logic        shoot_evt,
    input  logic        player_hit_evt,
    input  logic        alien_hit_evt,
    input  logic        ufo_hit_evt,
    output logic [31:0] fleet_period,
    output logic        play_ufo,
    output logic        stop_ufo,
    output logic        play_shoot,
    output logic        play_player_hit,
    output logic        play_alien_hit,
    output logic        play_ufo_hit,
    output logic [1:0]  dbg_state
);

    localparam logic [31:0] NOTE_PERIOD [4] = '{
        note_period(CLK_FREQ, 2'd0),
        note_period(CLK_FREQ, 2'd1),
        note_period(CLK_FREQ, 2'd2),
        note_period(CLK_FREQ, 2'd3)
    };

    fleet_state_t state;
    fleet_state_t next_state;
    logic [31:0]  timer;
    logic [31:0]  timer_inc;
    logic [31:0]  step_cycles;
    logic [31:0]  new_step;
    logic [31:0]  fleet_period_d;
    logic [1:0]   note_idx;
    logic         march_ok;
    logic         tone_entry;
    logic         note_adv;
    logic         note_rst;
    logic         timer_clr;

    assign march_ok  = game_active && (alien_count != 6'd0);
    assign timer_inc = timer + 32'd1;
    assign new_step  = 32'(MIN_STEP_CYCLES) + 32'(alien_count) * 32'(STEP_PER_ALIEN);
    assign dbg_state = state;

    // The timer counts from TONE entry through GAP, and separately through MUTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            step_cycles <= '0;
            note_idx    <= '0;
        end else begin
            state <= next_state;
            if (timer_clr) begin
                timer <= '0;
            end else begin
                timer <= timer_inc;
            end
            if (tone_entry) begin
                step_cycles <= new_step;
            end
            if (note_rst) begin
                note_idx <= '0;
            end else if (note_adv) begin
                note_idx <= note_idx + 2'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        tone_entry = 1'b0;
        note_adv   = 1'b0;
        note_rst   = 1'b0;
        timer_clr  = 1'b0;
        if (!march_ok) begin
            next_state = ST_IDLE;
            timer_clr  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_TONE;
                    tone_entry = 1'b1;
                    note_rst   = 1'b1;
                    timer_clr  = 1'b1;
                end
                ST_TONE: begin
                    if (player_hit_evt) begin
                        next_state = ST_MUTED;
                        timer_clr  = 1'b1;
                    end else if (timer_inc >= 32'(NOTE_CYCLES)) begin
                        // A step no longer than the note leaves no room for a gap.
                        if (32'(NOTE_CYCLES) >= step_cycles) begin
                            next_state = ST_TONE;
                            tone_entry = 1'b1;
                            note_adv   = 1'b1;
                            timer_clr  = 1'b1;
                        end else begin
                            next_state = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (player_hit_evt) begin
                        next_state = ST_MUTED;
                        timer_clr  = 1'b1;
                    end else if (timer_inc >= step_cycles) begin
                        next_state = ST_TONE;
                        tone_entry = 1'b1;
                        note_adv   = 1'b1;
                        timer_clr  = 1'b1;
                    end
                end
                ST_MUTED: begin
                    if (player_hit_evt) begin
                        timer_clr = 1'b1;
                    end else if (timer_inc >= 32'(MUTE_CYCLES)) begin
                        next_state = ST_TONE;
                        tone_entry = 1'b1;
                        timer_clr  = 1'b1;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                    timer_clr  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        fleet_period_d = '0;
        if (game_active && (state == ST_TONE)) begin
            fleet_period_d = NOTE_PERIOD[note_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fleet_period <= '0;
        end else begin
            fleet_period <= fleet_period_d;
        end
    end

    // UFO tracking; 'armed' keeps a level held high through reset from looking like a rise.
    logic ufo_prev;
    logic armed;
    logic ufo_playing;
    logic ufo_rise;
    logic ufo_fall;
    logic ufo_start;
    logic ufo_stop;

    assign ufo_rise  = armed & ufo_active & ~ufo_prev;
    assign ufo_fall  = ufo_prev & ~ufo_active;
    assign ufo_start = game_active & ufo_rise & ~ufo_hit_evt;
    assign ufo_stop  = ufo_playing & (ufo_fall | ufo_hit_evt | player_hit_evt | ~game_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ufo_prev    <= 1'b0;
            armed       <= 1'b0;
            ufo_playing <= 1'b0;
        end else begin
            ufo_prev <= ufo_active;
            armed    <= 1'b1;
            if (ufo_stop) begin
                ufo_playing <= 1'b0;
            end else if (ufo_start) begin
                ufo_playing <= 1'b1;
            end
        end
    end

    sfx_sequencer_event_pulser #(.HOLDOFF(SHOOT_HOLDOFF)) u_shoot (
        .clk(clk), .rst_n(rst_n), .trig(shoot_evt), .enable(game_active), .pulse(play_shoot)
    );

    sfx_sequencer_event_pulser #(.HOLDOFF(0)) u_alien_hit (
        .clk(clk), .rst_n(rst_n), .trig(alien_hit_evt), .enable(game_active), .pulse(play_alien_hit)
    );

    sfx_sequencer_event_pulser #(.HOLDOFF(0)) u_player_hit (
        .clk(clk), .rst_n(rst_n), .trig(player_hit_evt), .enable(game_active), .pulse(play_player_hit)
    );

    sfx_sequencer_event_pulser #(.HOLDOFF(0)) u_ufo_hit (
        .clk(clk), .rst_n(rst_n), .trig(ufo_hit_evt), .enable(game_active), .pulse(play_ufo_hit)
    );

    sfx_sequencer_event_pulser #(.HOLDOFF(0)) u_play_ufo (
        .clk(clk), .rst_n(rst_n), .trig(ufo_start), .enable(1'b1), .pulse(play_ufo)
    );

    sfx_sequencer_event_pulser #(.HOLDOFF(0)) u_stop_ufo (
        .clk(clk), .rst_n(rst_n), .trig(ufo_stop), .enable(1'b1), .pulse(stop_ufo)
    );

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios plus a random phase, every cycle
// compared against a time-based reference model of the sound rules.
module tb_sfx_sequencer;

    localparam int NC   = 4;
    localparam int MINS = 10;
    localparam int SPA  = 2;
    localparam int HOLD = 5;
    localparam int MUTE = 20;
    localparam logic [31:0] NP [4] = '{32'd1020408, 32'd1149425, 32'd1282051, 32'd1369863};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        game_active;
    logic [5:0]  alien_count;
    logic        ufo_active;
    logic        shoot_evt;
    logic        player_hit_evt;
    logic        alien_hit_evt;
    logic        ufo_hit_evt;
    logic [31:0] fleet_period;
    logic        play_ufo;
    logic        stop_ufo;
    logic        play_shoot;
    logic        play_player_hit;
    logic        play_alien_hit;
    logic        play_ufo_hit;
    logic [1:0]  dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: march described as age since the current note began.
    bit          m_march, m_muted, m_playing, m_armed, m_prev;
    int          m_age, m_note, m_len, m_hold;
    logic [31:0] e_fp;
    bit          e_pu, e_su, e_ps, e_pph, e_pah, e_puh;

    sfx_sequencer #(
        .CLK_FREQ(100_000_000), .NOTE_CYCLES(NC), .MIN_STEP_CYCLES(MINS),
        .STEP_PER_ALIEN(SPA), .SHOOT_HOLDOFF(HOLD), .MUTE_CYCLES(MUTE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_active(game_active), .alien_count(alien_count),
        .ufo_active(ufo_active), .shoot_evt(shoot_evt), .player_hit_evt(player_hit_evt),
        .alien_hit_evt(alien_hit_evt), .ufo_hit_evt(ufo_hit_evt), .fleet_period(fleet_period),
        .play_ufo(play_ufo), .stop_ufo(stop_ufo), .play_shoot(play_shoot),
        .play_player_hit(play_player_hit), .play_alien_hit(play_alien_hit),
        .play_ufo_hit(play_ufo_hit), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_march = 0; m_muted = 0; m_playing = 0; m_armed = 0; m_prev = 0;
        m_age = 0; m_note = 0; m_len = 0; m_hold = HOLD;
        e_fp = '0; e_pu = 0; e_su = 0; e_ps = 0; e_pph = 0; e_pah = 0; e_puh = 0;
    endtask

    task automatic model_update();
        bit rise, fall;
        int eff;
        e_fp  = (game_active && m_march && !m_muted && m_age < NC) ? NP[m_note] : 32'd0;
        e_ps  = game_active && shoot_evt && (m_hold >= HOLD);
        m_hold = e_ps ? 1 : ((m_hold < HOLD) ? m_hold + 1 : m_hold);
        e_pah = game_active && alien_hit_evt;
        e_pph = game_active && player_hit_evt;
        e_puh = game_active && ufo_hit_evt;
        rise  = m_armed && ufo_active && !m_prev;
        fall  = m_prev && !ufo_active;
        e_pu  = game_active && rise && !ufo_hit_evt;
        e_su  = m_playing && (fall || ufo_hit_evt || player_hit_evt || !game_active);
        if (e_su) m_playing = 0;
        else if (e_pu) m_playing = 1;
        m_prev  = ufo_active;
        m_armed = 1;
        if (!game_active || alien_count == 0) begin
            m_march = 0; m_muted = 0;
        end else if (!m_march) begin
            m_march = 1; m_muted = 0; m_note = 0; m_age = 0;
            m_len = MINS + int'(alien_count) * SPA;
        end else if (m_muted) begin
            if (player_hit_evt) m_age = 0;
            else if (m_age + 1 >= MUTE) begin
                m_muted = 0; m_age = 0; m_len = MINS + int'(alien_count) * SPA;
            end else m_age++;
        end else if (player_hit_evt) begin
            m_muted = 1; m_age = 0;
        end else begin
            eff = (m_len > NC) ? m_len : NC;
            m_age++;
            if (m_age >= eff) begin
                m_age = 0; m_note = (m_note + 1) % 4; m_len = MINS + int'(alien_count) * SPA;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("fleet_period", fleet_period, e_fp);
        check("play_ufo", 32'(play_ufo), 32'(e_pu));
        check("stop_ufo", 32'(stop_ufo), 32'(e_su));
        check("play_shoot", 32'(play_shoot), 32'(e_ps));
        check("play_player_hit", 32'(play_player_hit), 32'(e_pph));
        check("play_alien_hit", 32'(play_alien_hit), 32'(e_pah));
        check("play_ufo_hit", 32'(play_ufo_hit), 32'(e_puh));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fp"}, fleet_period, 32'd0);
        check({tag, "_pulses"}, 32'({play_ufo, stop_ufo, play_shoot, play_player_hit,
                                      play_alien_hit, play_ufo_hit}), 32'd0);
    endtask

    // Ticks until fleet_period goes from 0 to non-zero; n is the tick count.
    task automatic wait_rise(input string tag, output int n);
        logic [31:0] prev;
        bit done;
        prev = fleet_period;
        done = 0;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
            if (prev == 32'd0 && fleet_period != 32'd0) done = 1;
            prev = fleet_period;
        end
        if (!done) begin
            n_total++;
            $error("FAIL %s: observed no rise after %0d cycles expected a rise", tag, n);
        end
    endtask

    initial begin
        logic [31:0] fp_log [52];
        bit          ps_log [9];
        int          n, z;

        rst_n = 1'b0; game_active = 0; alien_count = '0; ufo_active = 0;
        shoot_evt = 0; player_hit_evt = 0; alien_hit_evt = 0; ufo_hit_evt = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // March cadence with one alien: 4-cycle tone in a 12-cycle step.
        game_active = 1; alien_count = 6'd1;
        for (int i = 0; i < 52; i++) begin
            tick();
            fp_log[i] = fleet_period;
        end
        check("cad_idle", fp_log[0], 32'd0);
        check("cad_n0_first", fp_log[1], NP[0]);
        check("cad_n0_last", fp_log[4], NP[0]);
        check("cad_gap_first", fp_log[5], 32'd0);
        check("cad_gap_last", fp_log[12], 32'd0);
        check("cad_n1", fp_log[13], NP[1]);
        check("cad_n2", fp_log[25], NP[2]);
        check("cad_n3", fp_log[37], NP[3]);
        check("cad_wrap", fp_log[49], NP[0]);

        // Tempo change mid-GAP takes effect at the next step.
        wait_rise("sync", n);
        repeat (6) tick();
        alien_count = 6'd3;
        wait_rise("tempo_a", n);
        check("tempo_keep_step", 32'(n + 6), 32'd12);
        wait_rise("tempo_b", n);
        check("tempo_new_step", 32'(n), 32'd16);
        repeat (6) tick();
        alien_count = 6'd0;
        tick();
        check("tempo_zero_idle", fleet_period, 32'd0);
        repeat (3) tick();
        alien_count = 6'd3;
        wait_rise("tempo_c", n);
        check("tempo_reentry_note0", fleet_period, NP[0]);
        wait_rise("tempo_d", n);
        check("tempo_reentry_step", 32'(n), 32'd16);
        check("tempo_reentry_note1", fleet_period, NP[1]);

        // Shoot holdoff: shots at t=0,3,6.
        for (int i = 0; i < 9; i++) begin
            shoot_evt = (i == 0 || i == 3 || i == 6);
            tick();
            ps_log[i] = play_shoot;
        end
        shoot_evt = 0;
        check("shoot_t1", 32'(ps_log[0]), 32'd1);
        check("shoot_t4", 32'(ps_log[3]), 32'd0);
        check("shoot_t7", 32'(ps_log[6]), 32'd1);
        check("shoot_t8", 32'(ps_log[7]), 32'd0);

        // UFO lifecycle.
        ufo_active = 1;
        tick();
        check("ufo_play", 32'(play_ufo), 32'd1);
        repeat (2) tick();
        ufo_hit_evt = 1;
        tick();
        ufo_hit_evt = 0;
        check("ufo_hit_play", 32'(play_ufo_hit), 32'd1);
        check("ufo_hit_stop", 32'(stop_ufo), 32'd1);
        repeat (2) tick();
        ufo_active = 0;
        tick();
        check("ufo_fall_nostop", 32'(stop_ufo), 32'd0);

        // Player hit during note 2 with the UFO playing.
        ufo_active = 1;
        tick();
        check("ufo_play2", 32'(play_ufo), 32'd1);
        n = 0;
        while (fleet_period != NP[2] && n < 200) begin
            tick();
            n++;
        end
        check("reach_note2", fleet_period, NP[2]);
        player_hit_evt = 1;
        tick();
        player_hit_evt = 0;
        check("phit_play", 32'(play_player_hit), 32'd1);
        check("phit_stop_ufo", 32'(stop_ufo), 32'd1);
        z = 0;
        tick();
        while (fleet_period == 32'd0 && z < 60) begin
            z++;
            tick();
        end
        check("mute_len", 32'(z), 32'd20);
        check("mute_resume_note2", fleet_period, NP[2]);
        ufo_active = 0;
        tick();
        check("ufo_fall_after_phit", 32'(stop_ufo), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            game_active    = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 39) == 0) alien_count = 6'($urandom_range(0, 6));
            if ($urandom_range(0, 14) == 0) ufo_active = ~ufo_active;
            shoot_evt      = ($urandom_range(0, 3) == 0);
            alien_hit_evt  = ($urandom_range(0, 7) == 0);
            ufo_hit_evt    = ($urandom_range(0, 9) == 0);
            player_hit_evt = ($urandom_range(0, 29) == 0);
            tick();
        end
        shoot_evt = 0; alien_hit_evt = 0; ufo_hit_evt = 0; player_hit_evt = 0;

        // Deactivate mid-TONE.
        game_active = 1; alien_count = 6'd2;
        wait_rise("deact_sync", n);
        tick();
        game_active = 0;
        tick();
        check("deact_fp", fleet_period, 32'd0);

        // Asynchronous reset mid-TONE, UFO level held high through release.
        game_active = 1; ufo_active = 1;
        wait_rise("rst_sync", n);
        tick();
        check("pre_rst_tone", 32'(fleet_period != 32'd0), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
